// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for alu_seq_reg.
//   master : drives start, ALU_op, A, B; observes busy, done, res, zero, overflow
//   slave  : the ALU stage itself
//   start     request, only honoured while busy=0
//   ALU_op    operation select, sampled with start
//   A, B      operands (A[4:0] = shift amount, B = shift source for SRL)
//   busy      SRL iterating
//   done      one-cycle pulse when res/zero/overflow were updated
//   res       registered result
//   zero      registered res==0
//   overflow  registered signed overflow (ADD/SUB only)
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       ALU_op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             overflow;

    modport master (
        output start, ALU_op, A, B,
        input  busy, done, res, zero, overflow
    );

    modport slave (
        input  start, ALU_op, A, B,
        output busy, done, res, zero, overflow
    );
endinterface

// File: rtl/alu_seq_reg.sv
// alu_seq_reg: registered, handshaked ALU stage.
// Single-cycle ops (AND, OR, ADD, XOR, NOR, SUB, SLT, SRL by 0) update
// res/zero/overflow on the start edge and pulse done the following cycle.
// SRL by n>0 shifts one bit per clock; busy is high while iterating and
// start is ignored until the result edge.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_if.slave (start, ALU_op, A, B -> busy, done, res, zero, overflow)
//
// Build option:
//   ALU_FAST_SHIFT_EN  when defined, SRL uses a combinational barrel shifter
//                      and completes in one cycle; busy is tied to 0 and the
//                      iterative shifter is not built.
//
// State table (iterative build):
//   state   | meaning
//   S_IDLE  | waiting for start; single-cycle ops complete here
//   S_SHIFT | SRL iterating one bit per clock, busy=1
//
// The shift amount is A[4:0], so WIDTH must be 32.
module alu_seq_reg #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign shamt   = bus.A[4:0];
    assign sum     = bus.A + bus.B;
    assign diff    = bus.A - bus.B;
    assign add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1]  != bus.A[WIDTH-1]);
    assign sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ALU_op)
            OP_AND: alu_res = bus.A & bus.B;
            OP_OR:  alu_res = bus.A | bus.B;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OP_XOR: alu_res = bus.A ^ bus.B;
            OP_NOR: alu_res = ~(bus.A | bus.B);
`ifdef ALU_FAST_SHIFT_EN
            OP_SRL: alu_res = bus.B >> shamt;
`else
            // Only reached for a zero shift amount; n>0 goes through S_SHIFT.
            OP_SRL: alu_res = bus.B;
`endif
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            default: alu_res = '0;
        endcase
    end

    logic [WIDTH-1:0] res_q,  res_nx;
    logic             zero_q, zero_nx;
    logic             ovf_q,  ovf_nx;
    logic             done_q, done_nx;

`ifdef ALU_FAST_SHIFT_EN

    always_comb begin
        res_nx  = res_q;
        zero_nx = zero_q;
        ovf_nx  = ovf_q;
        done_nx = 1'b0;
        if (bus.start) begin
            res_nx  = alu_res;
            zero_nx = (alu_res == '0);
            ovf_nx  = alu_ovf;
            done_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            res_q  <= res_nx;
            zero_q <= zero_nx;
            ovf_q  <= ovf_nx;
            done_q <= done_nx;
        end
    end

    assign bus.busy = 1'b0;

`else

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh,    sh_nx;
    logic [4:0]       cnt,   cnt_nx;
    logic             busy_q, busy_nx;
    logic [WIDTH-1:0] sh_shr;

    assign sh_shr = {1'b0, sh[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        cnt_nx   = cnt;
        res_nx   = res_q;
        zero_nx  = zero_q;
        ovf_nx   = ovf_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if ((bus.ALU_op == OP_SRL) && (shamt != 5'd0)) begin
                        sh_nx    = bus.B;
                        cnt_nx   = shamt;
                        busy_nx  = 1'b1;
                        state_nx = S_SHIFT;
                    end else begin
                        res_nx  = alu_res;
                        zero_nx = (alu_res == '0);
                        ovf_nx  = alu_ovf;
                        done_nx = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                sh_nx  = sh_shr;
                cnt_nx = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    res_nx   = sh_shr;
                    zero_nx  = (sh_shr == '0);
                    ovf_nx   = 1'b0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sh     <= '0;
            cnt    <= '0;
            res_q  <= '0;
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            sh     <= sh_nx;
            cnt    <= cnt_nx;
            res_q  <= res_nx;
            zero_q <= zero_nx;
            ovf_q  <= ovf_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

    assign bus.busy = busy_q;

`endif

    assign bus.res      = res_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_seq_reg.sv
module tb_alu_seq_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq_reg #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start cycle; returns at the falling edge after the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.ALU_op = op;
        bus.A      = a;
        bus.B      = b;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic test_reset();
        issue(3'b010, 32'h0000_0003, 32'h0000_0004);
        if (bus.res !== 32'h7) begin errors++; $display("FAIL pre_reset_res: got %h expected %h", bus.res, 32'h7); end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if (bus.res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h expected 0", bus.res); end
        checks++;
        if (bus.zero !== 1'b1 || bus.overflow !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got zero=%b ovf=%b busy=%b done=%b expected 1 0 0 0",
                     bus.zero, bus.overflow, bus.busy, bus.done);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.res !== 32'h0) begin
                errors++;
                $display("FAIL idle_no_done: got done=%b res=%h expected 0 0", bus.done, bus.res);
            end
            checks++;
        end
    endtask

    task automatic test_single_cycle();
        issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        if (bus.done !== 1'b1 || bus.res !== 32'h8000_0000 || bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL add_ovf: got done=%b res=%h ovf=%b zero=%b expected 1 80000000 1 0",
                     bus.done, bus.res, bus.overflow, bus.zero);
        end
        checks++;
        @(negedge clk);
        if (bus.done !== 1'b0 || bus.res !== 32'h8000_0000) begin
            errors++;
            $display("FAIL done_single_pulse: got done=%b res=%h expected 0 80000000", bus.done, bus.res);
        end
        checks++;
        issue(3'b110, 32'h5, 32'h5);
        if (bus.res !== 32'h0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL sub_zero: got res=%h zero=%b ovf=%b expected 0 1 0", bus.res, bus.zero, bus.overflow);
        end
        checks++;
        issue(3'b100, 32'hFFFF_0000, 32'h0000_FFFF);
        if (bus.res !== 32'h0 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL nor_zero: got res=%h zero=%b expected 0 1", bus.res, bus.zero);
        end
        checks++;
        issue(3'b000, 32'hFF00_FF00, 32'h0F0F_0F0F);
        if (bus.res !== 32'h0F00_0F00 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL and: got res=%h zero=%b expected 0f000f00 0", bus.res, bus.zero);
        end
        checks++;
        issue(3'b001, 32'hFF00_FF00, 32'h0F0F_0F0F);
        if (bus.res !== 32'hFF0F_FF0F) begin errors++; $display("FAIL or: got %h expected ff0fff0f", bus.res); end
        checks++;
        issue(3'b011, 32'hFF00_FF00, 32'h0F0F_0F0F);
        if (bus.res !== 32'hF00F_F00F) begin errors++; $display("FAIL xor: got %h expected f00ff00f", bus.res); end
        checks++;
    endtask

    task automatic test_slt();
        issue(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
        if (bus.res !== 32'h1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL slt_neg: got res=%h ovf=%b expected 1 0", bus.res, bus.overflow);
        end
        checks++;
        issue(3'b111, 32'h0000_0001, 32'hFFFF_FFFF);
        if (bus.res !== 32'h0 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL slt_pos: got res=%h zero=%b expected 0 1", bus.res, bus.zero);
        end
        checks++;
        // 0x80000000 < 0x7FFFFFFF signed, even though the raw difference is positive
        issue(3'b111, 32'h8000_0000, 32'h7FFF_FFFF);
        if (bus.res !== 32'h1) begin errors++; $display("FAIL slt_ovf: got %h expected 1", bus.res); end
        checks++;
        issue(3'b110, 32'h8000_0000, 32'h0000_0001);
        if (bus.res !== 32'h7FFF_FFFF || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf: got res=%h ovf=%b expected 7fffffff 1", bus.res, bus.overflow);
        end
        checks++;
    endtask

    task automatic test_srl();
        int cycles;
        int exp_cycles;
`ifdef ALU_FAST_SHIFT_EN
        exp_cycles = 0;
`else
        exp_cycles = 4;
`endif
        issue(3'b101, 32'h0000_0004, 32'hF000_0000);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 40) begin
            if (bus.done !== 1'b0 || bus.res !== 32'h7FFF_FFFF) begin
                errors++;
                $display("FAIL srl_hold: got done=%b res=%h expected 0 7fffffff", bus.done, bus.res);
            end
            checks++;
            cycles++;
            @(negedge clk);
        end
        if (cycles !== exp_cycles) begin errors++; $display("FAIL srl4_busy_cycles: got %0d expected %0d", cycles, exp_cycles); end
        checks++;
        if (bus.done !== 1'b1 || bus.res !== 32'h0F00_0000 || bus.overflow !== 1'b0 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL srl4_result: got done=%b res=%h ovf=%b zero=%b expected 1 0f000000 0 0",
                     bus.done, bus.res, bus.overflow, bus.zero);
        end
        checks++;
        @(negedge clk);
        if (bus.done !== 1'b0) begin errors++; $display("FAIL srl4_done_pulse: got %b expected 0", bus.done); end
        checks++;
        issue(3'b101, 32'h0000_0000, 32'h0000_1234);
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.res !== 32'h0000_1234) begin
            errors++;
            $display("FAIL srl0: got done=%b busy=%b res=%h expected 1 0 00001234", bus.done, bus.busy, bus.res);
        end
        checks++;
    endtask

    task automatic test_busy_lockout();
        int cycles;
        int exp_cycles;
`ifdef ALU_FAST_SHIFT_EN
        exp_cycles = 0;
`else
        exp_cycles = 31;
`endif
        issue(3'b101, 32'h0000_001F, 32'h8000_0000);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 40) begin
            // An AND of zeros would clear res if it were accepted.
            bus.start  = (cycles == 3);
            bus.ALU_op = 3'b000;
            bus.A      = 32'h0;
            bus.B      = 32'h0;
            cycles++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (cycles !== exp_cycles) begin errors++; $display("FAIL srl31_busy_cycles: got %0d expected %0d", cycles, exp_cycles); end
        checks++;
        if (bus.done !== 1'b1 || bus.res !== 32'h1) begin
            errors++;
            $display("FAIL srl31_result: got done=%b res=%h expected 1 00000001", bus.done, bus.res);
        end
        checks++;
        @(negedge clk);
        if (bus.done !== 1'b0 || bus.res !== 32'h1) begin
            errors++;
            $display("FAIL lockout_no_queue: got done=%b res=%h expected 0 00000001", bus.done, bus.res);
        end
        checks++;
    endtask

    task automatic test_reset_mid_shift();
        issue(3'b101, 32'h0000_001F, 32'h8000_0000);
        repeat (9) @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_before_reset: got %b expected 1", bus.busy); end
        checks++;
`endif
        #2 rst_n = 1'b0;
        #1;
        if (bus.res !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift_reset: got res=%h busy=%b done=%b zero=%b expected 0 0 0 1",
                     bus.res, bus.busy, bus.done, bus.zero);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (35) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start  = 1'b1;
        bus.ALU_op = 3'b010;
        bus.A      = 32'h1;
        bus.B      = 32'h2;
        @(negedge clk);
        if (bus.done !== 1'b1 || bus.res !== 32'h3) begin
            errors++;
            $display("FAIL b2b_first: got done=%b res=%h expected 1 00000003", bus.done, bus.res);
        end
        checks++;
        bus.ALU_op = 3'b001;
        bus.A      = 32'h10;
        bus.B      = 32'h01;
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.done !== 1'b1 || bus.res !== 32'h11) begin
            errors++;
            $display("FAIL b2b_second: got done=%b res=%h expected 1 00000011", bus.done, bus.res);
        end
        checks++;
        @(negedge clk);
        if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", bus.done); end
        checks++;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.ALU_op = 3'b000;
        bus.A      = 32'h0;
        bus.B      = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_cycle();
        test_slt();
        test_srl();
        test_busy_lockout();
        test_reset_mid_shift();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_reg.md
Name: alu_seq_reg

Overview:
Registered, handshaked ALU stage that computes a 32-bit result and latches it, together with status flags, for the downstream zero-detect/flag logic. The zero-detect consumer sits on this block's res bus. Single-cycle logical and arithmetic ops complete in one clock. SRL runs iteratively at one bit per clock, so the block carries a start/busy/done handshake toward the control FSM.

Parameters:
WIDTH, 32, operand/result width; shift amount is always A[4:0], so WIDTH must be 32.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only while busy=0
ALU_op  in  3  operation select, sampled with start
A  in  WIDTH  operand A; A[4:0] is the shift amount for SRL
B  in  WIDTH  operand B; B is the shift source for SRL
busy  out  1  high while an SRL is iterating
done  out  1  one-cycle pulse when res/zero/overflow have been updated
res  out  WIDTH  registered result
zero  out  1  registered, equals 1 when res==0
overflow  out  1  registered signed overflow; ADD/SUB only

Behaviour:
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 XOR
  - 100 NOR
  - 101 SRL: logical right shift of B by A[4:0]
  - 110 SUB: A-B
  - 111 SLT: res = {31'b0, signed A<B}
- Reset (async, any state, including mid-shift):
  - res=0, zero=1, overflow=0, busy=0, done=0
  - FSM=IDLE, shift register and counter cleared.
- FSM states: IDLE, SHIFT.
- IDLE:
  - Edge with start=1 and a non-SRL op, or SRL with A[4:0]=0:
    - res, zero, overflow written at that edge.
    - done=1 for the following cycle; FSM stays IDLE.
    - SRL by 0 gives res=B.
  - Edge with start=1, SRL, amount n>0:
    - load sh<=B, cnt<=n, busy<=1, FSM<=SHIFT.
    - res is unchanged.
  - start=0: hold all outputs; done=0.
- SHIFT:
  - Each edge: sh<=sh>>1 (MSB fill 0), cnt<=cnt-1.
  - On the edge where cnt goes 1->0: res<=final shifted value, zero updated, overflow<=0, busy<=0, done<=1, FSM<=IDLE.
  - Total latency from the start edge to the result edge is n cycles (n=1..31).
  - start is ignored while busy=1; no queuing.
- Back-to-back: start may be high in the same cycle done=1; it is accepted at the next edge.
- Arithmetic:
  - ADD/SUB are WIDTH-bit modulo; carry is discarded.
  - overflow: ADD = (A[31]==B[31]) && (sum[31]!=A[31]); SUB = (A[31]!=B[31]) && (diff[31]!=A[31]).
  - SLT is derived from diff[31] XOR sub_overflow.
  - overflow=0 for every op other than ADD/SUB.
- zero is always consistent with the registered res, updated on the same edge.
- done never asserts for two consecutive cycles from a single start.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined:
  - SRL uses a combinational barrel shifter and completes like a single-cycle op.
  - SHIFT state, counter and shift register are not synthesised.
  - busy is tied to 0.
- Undefined: iterative SRL exactly as specified in Behaviour.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run, then release -> res=0, zero=1, overflow=0, busy=0, done=0; no done pulse until the first start.
- Single-cycle ops:
  - ADD A=0x7FFFFFFF, B=1 -> res=0x80000000, overflow=1, zero=0, done one cycle after the start edge.
  - SUB A=5, B=5 -> res=0, zero=1, overflow=0.
  - NOR A=0xFFFF0000, B=0x0000FFFF -> res=0, zero=1.
- SLT signed: A=0xFFFFFFFF (-1), B=1 -> res=1. A=1, B=0xFFFFFFFF -> res=0. SUB A=0x80000000, B=1 -> overflow=1.
- Iterative SRL: A=4, B=0xF0000000 -> busy high for 4 cycles, res=0x0F000000 on the 4th edge, done pulse. A=0, B=0x1234 -> res=0x1234 after 1 cycle, busy never high.
- Busy lockout plus reset mid-shift:
  - SRL A=31, B=0x80000000; pulse start with AND during busy -> ignored; res=1 after 31 cycles.
  - Repeat and drop rst_n at cycle 10 -> immediate return to IDLE, res=0, busy=0.
- Fast shift build (ALU_FAST_SHIFT_EN defined): SRL A=31, B=0x80000000 -> res=1 with done one cycle after start; busy stays 0.
